// File: rtl/aes_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_arb_pkg                                                    |
// | Brief    : Shared types and default constants for the AES job arbiter:   |
// |            FSM state encoding, requester-id type and default timing.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package aes_arb_pkg;

  // Arbiter FSM states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  // Requester identity, carried one-hot (bit 0 = requester 0, bit 1 = requester 1).
  typedef logic [1:0] req_id_t;

  // Default number of cycles core_load is held per job.
  localparam int unsigned c_LOAD_CYCLES    = 2;

  // Default number of RUN cycles allowed before a job is aborted.
  localparam int unsigned c_TIMEOUT_CYCLES = 64;

endpackage : aes_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_arb2                                                       |
// | Brief    : Two-way round-robin selector. A lone request always wins; on  |
// |            a tie the requester that did not win last time is chosen.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rr_arb2
  import aes_arb_pkg::*;
(
  input  logic [1:0] req,    // per-requester request
  input  logic       last,   // index of the previous winner (0 or 1)
  output req_id_t    grant   // one-hot winner, zero when nobody requests
);

  // Pure combinational pick; the caller owns the last-winner state.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/aes_job_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_job_arbiter                                               |
// | Brief    : Shares one AES core between two requesters. A granted job's   |
// |            key/plaintext are registered to the core, core_load is pulsed |
// |            for LOAD_CYCLES, completion is awaited, and the ciphertext is |
// |            returned to the owning requester with a valid/ready handshake.|
// |            Build option: define AES_ARB_TIMEOUT_EN to abort jobs whose   |
// |            core never completes within TIMEOUT_CYCLES RUN cycles.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module aes_job_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES    = c_LOAD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = c_TIMEOUT_CYCLES
) (
  input  logic         clk,
  input  logic         reset,       // synchronous, active-low
  input  logic [1:0]   req,
  input  logic [127:0] key0,
  input  logic [127:0] pt0,
  input  logic [127:0] key1,
  input  logic [127:0] pt1,
  output logic [1:0]   gnt,
  output logic         core_load,
  output logic [127:0] core_key,
  output logic [127:0] core_pt,
  input  logic         core_done,
  input  logic [127:0] core_ct,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         busy
);

  // Last LOAD cycle index for the 4-bit load counter.
  localparam logic [3:0] c_load_last = 4'(LOAD_CYCLES - 1);

  // Elaboration-time guard on the legal parameter ranges.
  if (LOAD_CYCLES < 2 || LOAD_CYCLES > 15) begin : g_load_cycles_range
    $error("aes_job_arbiter: LOAD_CYCLES must be in 2..15");
  end
  if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("aes_job_arbiter: TIMEOUT_CYCLES must be in 16..255");
  end

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  req_id_t    w_rr_grant;     // round-robin pick for the current req
  req_id_t    r_owner;        // requester that owns the job in flight
  logic       r_last;         // previous winner index; 1 after reset
  logic [3:0] r_load_cnt;     // LOAD cycles elapsed
  logic       r_run_armed;    // high from the second RUN cycle on

  logic       w_grant_take;   // a grant is issued this cycle
  logic       w_load_end;     // final LOAD cycle
  logic       w_done_take;    // core completion accepted this cycle
  logic       w_timeout;      // job aborted this cycle
  logic       w_resp_take;    // owner accepts the response this cycle

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .last  (r_last),
    .grant (w_rr_grant)
  );

  assign w_grant_take = (r_state == IDLE) && (req != 2'b00);
  assign w_load_end   = (r_state == LOAD) && (r_load_cnt == c_load_last);
  // The first RUN cycle may still see a done left over from the previous job.
  assign w_done_take  = (r_state == RUN) && r_run_armed && core_done;
  assign w_resp_take  = (r_state == RESP) && ((rsp_ready & r_owner) != 2'b00);

`ifdef AES_ARB_TIMEOUT_EN
  localparam logic [7:0] c_to_last = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_to_cnt;
  logic       r_rsp_err;

  // A done arriving on the expiry cycle wins over the timeout.
  assign w_timeout = (r_state == RUN) && (r_to_cnt == c_to_last) && !w_done_take;

  // Count RUN cycles of the current job; idle at zero elsewhere.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (r_state == RUN) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Error flag: cleared by a completed job, set by an aborted one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rsp_err <= 1'b0;
    end else if (w_done_take) begin
      r_rsp_err <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_err <= 1'b1;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  // Without the timeout option RUN waits for the core indefinitely.
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_grant_take)             w_state_nxt = LOAD;
      LOAD: if (w_load_end)               w_state_nxt = RUN;
      RUN:  if (w_done_take || w_timeout) w_state_nxt = RESP;
      RESP: if (w_resp_take)              w_state_nxt = IDLE;
      default:                            w_state_nxt = IDLE;
    endcase
  end

  // Output decode; gnt is also held low while reset is asserted.
  always_comb begin
    gnt       = 2'b00;
    core_load = 1'b0;
    rsp_valid = 2'b00;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (reset) gnt = w_rr_grant;
      end
      LOAD:    core_load = 1'b1;
      RUN:     core_load = 1'b0;
      RESP:    rsp_valid = r_owner;
      default: busy      = 1'b0;
    endcase
  end

  // Job context: operands, owner and round-robin pointer change only on a grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      core_key <= '0;
      core_pt  <= '0;
      r_owner  <= 2'b00;
      r_last   <= 1'b1;
    end else if (w_grant_take) begin
      core_key <= w_rr_grant[1] ? key1 : key0;
      core_pt  <= w_rr_grant[1] ? pt1  : pt0;
      r_owner  <= w_rr_grant;
      r_last   <= w_rr_grant[1];
    end
  end

  // LOAD-length counter and the RUN first-cycle qualifier.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_load_cnt  <= '0;
      r_run_armed <= 1'b0;
    end else begin
      if (r_state == LOAD && !w_load_end) begin
        r_load_cnt <= r_load_cnt + 4'd1;
      end else begin
        r_load_cnt <= '0;
      end
      // RUN is only ever entered from LOAD, so this is low on RUN cycle one.
      r_run_armed <= (r_state == RUN);
    end
  end

  // Response data: ciphertext on completion, zero on abort, otherwise held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_data <= '0;
    end else if (w_done_take) begin
      rsp_data <= core_ct;
    end else if (w_timeout) begin
      rsp_data <= '0;
    end
  end

endmodule : aes_job_arbiter
`default_nettype wire

// File: tb/tb_aes_job_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_aes_job_arbiter                                            |
// | Brief    : Directed self-checking bench for aes_job_arbiter with a       |
// |            scoreboard of expected responses and a behavioural core.      |
// |            Define AES_ARB_TIMEOUT_EN to include the timeout scenario.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_aes_job_arbiter;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 64;
`endif
  localparam int unsigned LC = 2;

  localparam logic [127:0] c_fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_fips_pt  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] c_fips_ct  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk       = 1'b0;
  logic         reset     = 1'b0;
  logic [1:0]   req       = 2'b00;
  logic [127:0] key0      = '0;
  logic [127:0] pt0       = '0;
  logic [127:0] key1      = '0;
  logic [127:0] pt1       = '0;
  logic         core_done = 1'b0;
  logic [127:0] core_ct   = '0;
  logic [1:0]   rsp_ready = 2'b00;
  logic [1:0]   gnt;
  logic         core_load;
  logic [127:0] core_key;
  logic [127:0] core_pt;
  logic [1:0]   rsp_valid;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic         busy;

  aes_job_arbiter #(
    .LOAD_CYCLES    (LC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .key0      (key0),
    .pt0       (pt0),
    .key1      (key1),
    .pt1       (pt1),
    .gnt       (gnt),
    .core_load (core_load),
    .core_key  (core_key),
    .core_pt   (core_pt),
    .core_done (core_done),
    .core_ct   (core_ct),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]   owner;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] data;
    logic         err;
  } exp_t;

  exp_t sb[$];

  // Behavioural core: the FIPS-197 vector, otherwise a cheap keyed mix.
  function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] p);
    if (k == c_fips_key && p == c_fips_pt) return c_fips_ct;
    return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_5a5a_a5a5_a5a5_0f0f_f0f0_3c3c_c3c3;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic scramble_inputs();
    key0 = rnd128(); pt0 = rnd128(); key1 = rnd128(); pt1 = rnd128();
  endtask

  // One complete job: grant, load, run (done raised on RUN cycle k+1), response.
  task automatic do_job(input string nm, input logic [1:0] req_v, input logic [1:0] exp_gnt,
                        input int k, input int hold, input bit stale,
                        input logic [1:0] req_after, input logic [1:0] req_in_resp);
    exp_t e;
    int   nload;
    req = req_v;
    #1;
    n_checks++;
    if (gnt !== exp_gnt) begin
      n_fail++; $display("FAIL %s grant: got %b want %b", nm, gnt, exp_gnt);
    end
    e.owner = exp_gnt;
    e.key   = exp_gnt[1] ? key1 : key0;
    e.pt    = exp_gnt[1] ? pt1  : pt0;
    e.data  = core_model(e.key, e.pt);
    e.err   = 1'b0;
    sb.push_back(e);
    if (stale) begin
      core_done = 1'b1; core_ct = e.data;
    end
    tick();
    req = req_after;
    scramble_inputs();
    n_checks++;
    if (gnt !== 2'b00) begin
      n_fail++; $display("FAIL %s grant pulse width: got %b want 00", nm, gnt);
    end
    nload = 0;
    while (core_load === 1'b1 && nload < 20) begin
      nload++;
      tick();
    end
    n_checks++;
    if (nload != LC) begin
      n_fail++; $display("FAIL %s core_load cycles: got %0d want %0d", nm, nload, LC);
    end
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL %s early rsp_valid in RUN 1: got %b want 00", nm, rsp_valid);
    end
    for (int i = 0; i < k; i++) begin
      tick();
      n_checks++;
      if (rsp_valid !== 2'b00) begin
        n_fail++; $display("FAIL %s early rsp_valid at RUN %0d: got %b want 00", nm, i + 2, rsp_valid);
      end
    end
    core_done = 1'b1; core_ct = e.data;
    tick();
    core_done = 1'b0; core_ct = ~e.data;
    if (sb.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL %s scoreboard: got empty want entry", nm);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (rsp_valid !== e.owner || gnt !== 2'b00) begin
        n_fail++; $display("FAIL %s rsp_valid/gnt: got %b/%b want %b/00", nm, rsp_valid, gnt, e.owner);
      end
      n_checks++;
      if (rsp_data !== e.data || rsp_err !== e.err) begin
        n_fail++; $display("FAIL %s rsp_data/err: got %h/%b want %h/%b", nm, rsp_data, rsp_err, e.data, e.err);
      end
      n_checks++;
      if (core_key !== e.key || core_pt !== e.pt) begin
        n_fail++; $display("FAIL %s core operands: got %h/%h want %h/%h", nm, core_key, core_pt, e.key, e.pt);
      end
      req       = req_in_resp;
      rsp_ready = ~e.owner;
      for (int i = 0; i < hold; i++) begin
        tick();
        n_checks++;
        if (rsp_valid !== e.owner || gnt !== 2'b00 || rsp_data !== e.data) begin
          n_fail++; $display("FAIL %s held response %0d: got %b/%b/%h want %b/00/%h",
                             nm, i, rsp_valid, gnt, rsp_data, e.owner, e.data);
        end
      end
      rsp_ready = e.owner;
      tick();
      rsp_ready = 2'b00;
      n_checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        n_fail++; $display("FAIL %s after accept: got valid %b busy %b want 00/0", nm, rsp_valid, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({gnt, rsp_valid, core_load, busy, rsp_err} !== 7'b0) begin
      n_fail++; $display("FAIL reset controls: got gnt %b valid %b load %b busy %b err %b want all 0",
                         gnt, rsp_valid, core_load, busy, rsp_err);
    end
    n_checks++;
    if (core_key !== '0 || core_pt !== '0 || rsp_data !== '0) begin
      n_fail++; $display("FAIL reset data: got %h/%h/%h want 0", core_key, core_pt, rsp_data);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_tie_twice();
    scramble_inputs();
    do_job("tie_first", 2'b11, 2'b01, 5, 0, 1'b0, 2'b11, 2'b11);
    do_job("tie_second", 2'b11, 2'b10, 5, 0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic test_single_job();
    key0 = c_fips_key; pt0 = c_fips_pt; key1 = rnd128(); pt1 = rnd128();
    do_job("single_fips", 2'b01, 2'b01, 11, 0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic test_backpressure();
    scramble_inputs();
    do_job("backpressure", 2'b01, 2'b01, 4, 5, 1'b0, 2'b00, 2'b10);
    #1;
    n_checks++;
    if (gnt !== 2'b10) begin
      n_fail++; $display("FAIL held-off request grant: got %b want 10", gnt);
    end
    do_job("after_backpressure", 2'b10, 2'b10, 3, 0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic test_stale_done();
    scramble_inputs();
    do_job("stale_done", 2'b10, 2'b10, 1, 0, 1'b1, 2'b00, 2'b00);
  endtask

  task automatic test_reset_mid_run();
    int n;
    scramble_inputs();
    req = 2'b01;
    #1;
    n_checks++;
    if (gnt !== 2'b01) begin
      n_fail++; $display("FAIL mid_run grant: got %b want 01", gnt);
    end
    tick();
    req = 2'b00;
    n = 0;
    while (core_load === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({gnt, rsp_valid, core_load, busy, rsp_err} !== 7'b0) begin
      n_fail++; $display("FAIL mid_run reset controls: got gnt %b valid %b load %b busy %b err %b want all 0",
                         gnt, rsp_valid, core_load, busy, rsp_err);
    end
    n_checks++;
    if (core_key !== '0 || core_pt !== '0 || rsp_data !== '0) begin
      n_fail++; $display("FAIL mid_run reset data: got %h/%h/%h want 0", core_key, core_pt, rsp_data);
    end
    reset = 1'b1;
    scramble_inputs();
    do_job("post_reset_tie", 2'b11, 2'b01, 3, 0, 1'b0, 2'b00, 2'b00);
  endtask

`ifdef AES_ARB_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    int   n;
    scramble_inputs();
    req = 2'b10;
    #1;
    n_checks++;
    if (gnt !== 2'b10) begin
      n_fail++; $display("FAIL timeout grant: got %b want 10", gnt);
    end
    e.owner = 2'b10; e.key = key1; e.pt = pt1; e.data = '0; e.err = 1'b1;
    sb.push_back(e);
    tick();
    req = 2'b00;
    n = 0;
    while (core_load === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    n = 0;
    while (rsp_valid === 2'b00 && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != TO) begin
      n_fail++; $display("FAIL timeout RUN cycles: got %0d want %0d", n, TO);
    end
    e = sb.pop_front();
    n_checks++;
    if (rsp_valid !== e.owner || rsp_err !== e.err || rsp_data !== e.data) begin
      n_fail++; $display("FAIL timeout response: got %b/%b/%h want %b/%b/%h",
                         rsp_valid, rsp_err, rsp_data, e.owner, e.err, e.data);
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout accept busy: got %b want 0", busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tie_twice();
    test_single_job();
    test_backpressure();
    test_stale_done();
    test_reset_mid_run();
`ifdef AES_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_aes_job_arbiter
`default_nettype wire

// File: doc/aes_job_arbiter.md
AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- LOAD_CYCLES, 2, cycles core_load is held high per job (legal range 2..15).
- TIMEOUT_CYCLES, 64, RUN-state cycles allowed before abort (legal range 16..255).
REQ-002 Ports SHALL be, one per line:
- clk  in  1  clock; all logic on posedge clk.
- reset  in  1  reset, synchronous, active-low.
- req  in  2  per-requester job request (level).
- key0, pt0  in  128 each  requester 0 key and plaintext.
- key1, pt1  in  128 each  requester 1 key and plaintext.
- gnt  out  2  one-hot, one-cycle grant pulse.
- core_load  out  1  load strobe to the AES core.
- core_key, core_pt  out  128 each  registered key and plaintext to the core.
- core_done  in  1  core completion flag (level).
- core_ct  in  128  core ciphertext.
- rsp_valid  out  2  one-hot response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  128  captured ciphertext.
- rsp_err  out  1  job aborted by timeout.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, LOAD, RUN, RESP.
REQ-004 IDLE: if any req bit is set, the block SHALL:
- pick a winner;
- pulse gnt[winner] for that cycle;
- latch the winner's key/pt into core_key/core_pt;
- record the owner;
- go to LOAD on the next cycle.
If no req bit is set, the FSM SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin over two requesters:
- single request: that requester wins;
- both requesting: the requester that did not win last wins;
- the last-winner pointer SHALL update only on a grant.
REQ-006 LOAD: core_load SHALL be 1 for exactly LOAD_CYCLES consecutive cycles, counted by a 4-bit counter, then the FSM SHALL go to RUN.
REQ-007 RUN:
- core_load SHALL be 0;
- core_done SHALL be ignored in the first RUN cycle, because a stale done may still be high;
- from the second RUN cycle on, core_done=1 SHALL cause core_ct to be captured into rsp_data, rsp_err to be set to 0, and the FSM to go to RESP.
REQ-008 RESP:
- rsp_valid[owner] SHALL be 1 and held with rsp_data stable until rsp_ready[owner]=1;
- on that cycle the FSM SHALL return to IDLE;
- rsp_ready of the non-owner SHALL be ignored.
REQ-009 Job latency SHALL be exactly 1 + LOAD_CYCLES + (cycles to core_done) + 1 cycles from grant to the first rsp_valid cycle.
REQ-010 core_key and core_pt SHALL change only on a grant; requester inputs SHALL be don't-care after the grant cycle.
REQ-011 A req arriving in any non-IDLE state SHALL be held off, with no gnt, until IDLE.
REQ-012 Simultaneous rsp_ready and new req from the same requester SHALL complete the response, and the new request SHALL be granted in the following IDLE cycle.
REQ-013 gnt and rsp_valid SHALL never be non-zero in the same cycle.

Reset
REQ-014 On reset=0 at a clock edge, regardless of current state (including mid-LOAD or mid-RUN), the block SHALL enter IDLE, and:
- gnt, rsp_valid and core_load SHALL be 0;
- core_key, core_pt, rsp_data and rsp_err SHALL be 0;
- busy SHALL be 0;
- all counters SHALL be 0;
- the last-winner pointer SHALL be 1, so requester 0 wins the first tie.

Configuration
REQ-015 Macro AES_ARB_TIMEOUT_EN SHALL select the timeout behaviour.
- Defined: an 8-bit counter runs in RUN; reaching TIMEOUT_CYCLES without core_done SHALL set rsp_err=1 and rsp_data=0, and enter RESP; a core_done and the timeout in the same cycle SHALL resolve as done.
- Undefined: RUN SHALL wait indefinitely, rsp_err SHALL be tied to 0, and no timeout counter SHALL exist.

Structure
REQ-016 Package aes_arb_pkg SHALL hold:
- the state enum type (IDLE/LOAD/RUN/RESP);
- the default LOAD_CYCLES and TIMEOUT_CYCLES constants;
- the 2-bit requester-id type.
REQ-017 Round-robin selection SHALL be a separate sub-module rr_arb2 (inputs req, last; output one-hot grant), instantiated once.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Single job: req=01, key0=2b7e151628aed2a6abf7158809cf4f3c, pt0=3243f6a8885a308d313198a2e0370734, core model done after 11 cycles, then rsp_ready[0]=1 -> gnt=01 for 1 cycle; core_load high 2 cycles; rsp_valid=01; rsp_data=3925841d02dc09fbdc118597196a0b32; rsp_err=0.
- Tie twice: req=11 held for two jobs -> first gnt=01, second gnt=10; responses go to the matching rsp_valid bit.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable for 5 cycles; new req=10 not granted until 1 cycle after the accept.
- Stale done: core_done held 1 entering RUN -> no capture in the first RUN cycle; capture on the second RUN cycle.
- Reset mid-RUN: reset=0 for 1 cycle at RUN cycle 3 -> next cycle IDLE; all outputs 0; next tie grants requester 0.
- Timeout (AES_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): core_done never asserted -> after 16 RUN cycles rsp_valid set with rsp_err=1 and rsp_data=0.
